// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential +4 advance with branch/mret/trap redirects.
// Redirects that arrive while fetch is held are latched and applied once the hold drops.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            busywait,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_epc,
    input  logic            mret_req,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] epc_out,
    output logic            redirect_pend
);

    typedef enum logic [1:0] {
        K_NONE   = 2'd0,
        K_BRANCH = 2'd1,
        K_MRET   = 2'd2,
        K_TRAP   = 2'd3
    } kind_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    kind_t           pend_kind_q, pend_kind_d;

    kind_t           new_kind, win_kind;
    logic [XLEN-1:0] new_target, win_target;
    logic            new_wins;
    logic            hold;

    assign hold     = busywait | stall;
    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        new_kind   = K_NONE;
        new_target = '0;
        if (trap_req) begin
            new_kind   = K_TRAP;
            new_target = TRAP_VECTOR & ALIGN_MASK;
        end else if (mret_req) begin
            // The return address is frozen here, so a later EPC update cannot move it.
            new_kind   = K_MRET;
            new_target = epc_q & ALIGN_MASK;
        end else if (branch_taken) begin
            new_kind   = K_BRANCH;
            new_target = branch_target & ALIGN_MASK;
        end

        // Equal rank goes to the newer request.
        new_wins   = (new_kind != K_NONE) && (new_kind >= pend_kind_q);
        win_kind   = new_wins ? new_kind   : pend_kind_q;
        win_target = new_wins ? new_target : pend_target_q;

        pc_d          = pc_q;
        pend_kind_d   = pend_kind_q;
        pend_target_d = pend_target_q;
        epc_d         = epc_q;

        if (hold) begin
            if (new_wins) begin
                pend_kind_d   = new_kind;
                pend_target_d = new_target;
            end
        end else begin
            pc_d          = (win_kind != K_NONE) ? win_target : pc_plus4;
            pend_kind_d   = K_NONE;
            pend_target_d = '0;
        end

        // A nested trap while one is already pending must not clobber the saved EPC.
        if (trap_req && (pend_kind_q != K_TRAP)) begin
            epc_d = trap_epc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            pend_kind_q   <= K_NONE;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            pend_kind_q   <= pend_kind_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc_out        = pc_q;
    assign epc_out       = epc_q;
    assign redirect_pend = (pend_kind_q != K_NONE);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected pc/epc/pending state is queued per step and
// compared one time unit after the following rising edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        busywait, stall, branch_taken, trap_req, mret_req;
    logic [31:0] branch_target, trap_epc;
    logic [31:0] pc_out, pc_plus4, epc_out;
    logic        redirect_pend;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        pend;
    } exp_t;

    exp_t sb[$];

    pc_gen #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .busywait(busywait),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .trap_req(trap_req),
        .trap_epc(trap_epc),
        .mret_req(mret_req),
        .pc_out(pc_out),
        .pc_plus4(pc_plus4),
        .epc_out(epc_out),
        .redirect_pend(redirect_pend)
    );

    always #5 clk = ~clk;

    task automatic compare_head();
        exp_t e;
        logic [31:0] exp_p4;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        exp_p4 = e.pc + 32'd4;
        checks++;
        assert (pc_out === e.pc) else begin
            errors++;
            $error("FAIL %s.pc observed=%h expected=%h", e.tag, pc_out, e.pc);
        end
        checks++;
        assert (pc_plus4 === exp_p4) else begin
            errors++;
            $error("FAIL %s.pc_plus4 observed=%h expected=%h", e.tag, pc_plus4, exp_p4);
        end
        checks++;
        assert (epc_out === e.epc) else begin
            errors++;
            $error("FAIL %s.epc observed=%h expected=%h", e.tag, epc_out, e.epc);
        end
        checks++;
        assert (redirect_pend === e.pend) else begin
            errors++;
            $error("FAIL %s.pend observed=%b expected=%b", e.tag, redirect_pend, e.pend);
        end
        $display("step %-12s pc=%h epc=%h pend=%b", e.tag, pc_out, epc_out, redirect_pend);
    endtask

    // Compare current outputs without waiting for a clock edge.
    task automatic check_now(input string tag, input logic [31:0] pc,
                             input logic [31:0] epc, input logic pend);
        sb.push_back('{tag, pc, epc, pend});
        compare_head();
    endtask

    // Expectation for the state after the next rising edge.
    task automatic step(input string tag, input logic [31:0] pc,
                        input logic [31:0] epc, input logic pend);
        sb.push_back('{tag, pc, epc, pend});
        @(posedge clk);
        #1;
        compare_head();
    endtask

    task automatic drive(input logic bw, input logic st, input logic br,
                         input logic [31:0] bt, input logic tr,
                         input logic [31:0] te, input logic mr);
        busywait      = bw;
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        trap_req      = tr;
        trap_epc      = te;
        mret_req      = mr;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        #1;
        check_now("reset", 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_now("rel0", 32'h0, 32'h0, 1'b0);
        step("seq4", 32'h4, 32'h0, 1'b0);
        step("seq8", 32'h8, 32'h0, 1'b0);
        step("seqC", 32'hC, 32'h0, 1'b0);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        check_now("async_rst", 32'h0, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        step("re4", 32'h4, 32'h0, 1'b0);
        step("re8", 32'h8, 32'h0, 1'b0);
        step("reC", 32'hC, 32'h0, 1'b0);
        step("re10", 32'h10, 32'h0, 1'b0);

        // Plain hold.
        drive(1, 0, 0, 32'h0, 0, 32'h0, 0);
        step("hold1", 32'h10, 32'h0, 1'b0);
        step("hold2", 32'h10, 32'h0, 1'b0);
        step("hold3", 32'h10, 32'h0, 1'b0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("hold_rel", 32'h14, 32'h0, 1'b0);

        // Latched branch with misaligned target.
        drive(1, 0, 1, 32'h203, 0, 32'h0, 0);
        step("br_latch", 32'h14, 32'h0, 1'b1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("br_apply", 32'h200, 32'h0, 1'b0);

        // Trap beats branch in the same cycle.
        drive(0, 0, 1, 32'h80, 1, 32'h44, 0);
        step("prio_trap", 32'h100, 32'h44, 1'b0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("after_trap", 32'h104, 32'h44, 1'b0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 1);
        step("mret", 32'h44, 32'h44, 1'b0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("after_mret", 32'h48, 32'h44, 1'b0);

        // Pending trap outranks later branch; nested trap keeps first EPC.
        drive(0, 1, 0, 32'h0, 1, 32'h48, 0);
        step("tp_latch", 32'h48, 32'h48, 1'b1);
        drive(0, 1, 1, 32'h300, 0, 32'h0, 0);
        step("tp_newbr", 32'h48, 32'h48, 1'b1);
        drive(0, 1, 0, 32'h0, 1, 32'h99, 0);
        step("tp_nested", 32'h48, 32'h48, 1'b1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("tp_apply", 32'h100, 32'h48, 1'b0);

        // Branch latched first, then trap arrives.
        drive(0, 1, 1, 32'h300, 0, 32'h0, 0);
        step("bt_latch", 32'h100, 32'h48, 1'b1);
        drive(0, 1, 0, 32'h0, 1, 32'h60, 0);
        step("bt_trap", 32'h100, 32'h60, 1'b1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("bt_apply", 32'h100, 32'h60, 1'b0);
        step("bt_next", 32'h104, 32'h60, 1'b0);

        // Latched mret uses EPC captured at latch time.
        drive(0, 1, 0, 32'h0, 0, 32'h0, 1);
        step("mr_latch", 32'h104, 32'h60, 1'b1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("mr_apply", 32'h60, 32'h60, 1'b0);

        // Equal rank: newer branch replaces pending one.
        drive(0, 1, 1, 32'h400, 0, 32'h0, 0);
        step("eq_first", 32'h60, 32'h60, 1'b1);
        drive(1, 0, 1, 32'h500, 0, 32'h0, 0);
        step("eq_second", 32'h60, 32'h60, 1'b1);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("eq_apply", 32'h500, 32'h60, 1'b0);

        // Wrap at top of address space.
        drive(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0, 0);
        step("to_top", 32'hFFFF_FFFC, 32'h60, 1'b0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        step("wrap", 32'h0, 32'h60, 1'b0);

        // Reset while a redirect is pending drops it.
        drive(0, 1, 1, 32'h700, 0, 32'h0, 0);
        step("rp_latch", 32'h0, 32'h60, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_now("rp_reset", 32'h0, 32'h0, 1'b0);
        drive(0, 0, 0, 32'h0, 0, 32'h0, 0);
        #1;
        rst = 1'b0;
        step("rp_after", 32'h4, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
